dvp_rx_capture: RTL and testbench

DVP_RX_CAPTURE -- requirements
Module: dvp_rx_capture

---
 rtl/dcasic_pkg.sv | 22 ++
 rtl/sync_fifo.sv | 49 ++++
 rtl/dvp_rx_capture.sv | 173 +++++++++++++++++
 tb/tb_dvp_rx_capture.sv | 294 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dcasic_pkg.sv
`timescale 1ns / 1ps
// Shared types and defaults for the DVP capture path.
package dcasic_pkg;

    localparam int IMG_W_DEF = 640;
    localparam int IMG_H_DEF = 480;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        VS_HIGH = 2'd1,
        ACTIVE  = 2'd2
    } cap_state_t;

    // One buffered pixel with its frame-position tags (19 bits).
    typedef struct packed {
        logic        sof;
        logic        eol;
        logic        eof;
        logic [15:0] data;
    } pix_word_t;

endpackage

// File: rtl/sync_fifo.sv
`timescale 1ns / 1ps
// First-word fall-through FIFO: rd_data always shows the head entry while
// not empty. A write on a full FIFO is accepted only if a read happens in
// the same cycle, which frees the slot being written.
module sync_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 4
) (
    input  logic             sys_clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q;
    logic [AW:0]      rd_ptr_q;
    logic             do_rd;
    logic             do_wr;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr_q[AW-1:0]];

    // Pointer update; the extra MSB distinguishes full from empty.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_rd) rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Storage write; contents need no reset because empty masks them.
    always_ff @(posedge sys_clk) begin
        if (do_wr) mem[wr_ptr_q[AW-1:0]] <= wr_data;
    end

endmodule

// File: rtl/dvp_rx_capture.sv
`timescale 1ns / 1ps
// DVP camera receiver: oversamples the camera bus in the sys_clk domain,
// assembles RGB565 pixels from byte pairs and buffers them with frame tags.
//
// state   | meaning
// IDLE    | not capturing; waiting for vsync to go high
// VS_HIGH | vertical blanking; cap_en is sampled when vsync falls
// ACTIVE  | capturing lines of the current frame
module dvp_rx_capture
    import dcasic_pkg::*;
#(
    parameter int DVP_DATA_W = 8,
    parameter int IMG_W      = IMG_W_DEF,
    parameter int IMG_H      = IMG_H_DEF,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  sys_clk,
    input  logic                  rst_n,
    input  logic                  cap_en,
    input  logic                  dvp_pclk_i,
    input  logic [DVP_DATA_W-1:0] dvp_d_i,
    input  logic                  dvp_href_i,
    input  logic                  dvp_vsync_i,
    output logic [15:0]           pix_data_o,
    output logic                  pix_valid_o,
    input  logic                  pix_ready_i,
    output logic                  pix_sof_o,
    output logic                  pix_eol_o,
    output logic                  pix_eof_o,
    output logic                  ovf_o,
    output logic                  err_o,
    input  logic                  err_clr_i
);
    localparam int SW = DVP_DATA_W + 3;
    localparam int PW = $clog2(IMG_W + 1);
    localparam int LW = $clog2(IMG_H + 1);
    localparam logic [PW-1:0] PIX_LAST  = PW'(IMG_W - 1);
    localparam logic [PW-1:0] PIX_FULL  = PW'(IMG_W);
    localparam logic [LW-1:0] LINE_LAST = LW'(IMG_H - 1);
    localparam logic [LW-1:0] LINE_FULL = LW'(IMG_H);

    cap_state_t            state_q, state_d;
    logic [SW-1:0]         sync1_q, sync2_q;
    logic                  pclk_prev_q, href_prev_q;
    logic                  pclk_s, href_s, vsync_s;
    logic [DVP_DATA_W-1:0] d_s;
    logic                  strobe, href_fall;
    logic                  cap_act, byte_stb, lo_stb, in_bounds;
    logic                  line_end, line_bad, drop_err;
    logic                  phase_q;
    logic [7:0]            hi_q;
    logic [PW-1:0]         pix_cnt_q;
    logic [LW-1:0]         line_cnt_q;
    logic                  push_vld_q;
    pix_word_t             push_word_q;
    pix_word_t             head;
    logic                  fifo_full, fifo_empty, pop;

    // All camera signals share the same two flops so data stays aligned with pclk.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            sync1_q     <= '0;
            sync2_q     <= '0;
            pclk_prev_q <= 1'b0;
            href_prev_q <= 1'b0;
        end else begin
            sync1_q     <= {dvp_pclk_i, dvp_href_i, dvp_vsync_i, dvp_d_i};
            sync2_q     <= sync1_q;
            pclk_prev_q <= pclk_s;
            href_prev_q <= href_s;
        end
    end

    assign pclk_s    = sync2_q[SW-1];
    assign href_s    = sync2_q[SW-2];
    assign vsync_s   = sync2_q[SW-3];
    assign d_s       = sync2_q[DVP_DATA_W-1:0];
    assign strobe    = pclk_s && !pclk_prev_q;
    assign href_fall = href_prev_q && !href_s;

    // vsync overrides href: nothing is captured during blanking.
    assign cap_act   = (state_q == ACTIVE) && !vsync_s;
    assign byte_stb  = cap_act && strobe && href_s;
    assign lo_stb    = byte_stb && phase_q;
    assign in_bounds = (pix_cnt_q < PIX_FULL) && (line_cnt_q < LINE_FULL);
    assign line_end  = cap_act && href_fall;
    assign line_bad  = line_end && (phase_q || (pix_cnt_q != PIX_FULL));
    assign drop_err  = lo_stb && !in_bounds;

    // State register.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Frame sequencing; cap_en only matters on the falling edge of vsync.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (vsync_s)  state_d = VS_HIGH;
            VS_HIGH: if (!vsync_s) state_d = cap_en ? ACTIVE : IDLE;
            ACTIVE:  if (vsync_s)  state_d = VS_HIGH;
            default: state_d = IDLE;
        endcase
    end

    // Byte phase and pixel/line position; everything is discarded outside ACTIVE.
    always_ff @(posedge sys_clk) begin
        if (!rst_n || (state_q != ACTIVE)) begin
            phase_q    <= 1'b0;
            hi_q       <= '0;
            pix_cnt_q  <= '0;
            line_cnt_q <= '0;
        end else if (line_end) begin
            phase_q   <= 1'b0;
            pix_cnt_q <= '0;
            if (line_cnt_q != LINE_FULL) line_cnt_q <= line_cnt_q + 1'b1;
        end else if (byte_stb) begin
            phase_q <= !phase_q;
            if (!phase_q)       hi_q      <= d_s[7:0];
            else if (in_bounds) pix_cnt_q <= pix_cnt_q + 1'b1;
        end
    end

    // Completed pixel is staged for one cycle before entering the FIFO.
    always_ff @(posedge sys_clk) begin
        if (!rst_n) begin
            push_vld_q  <= 1'b0;
            push_word_q <= '0;
        end else begin
            push_vld_q <= lo_stb && in_bounds;
            if (lo_stb) begin
                push_word_q.sof  <= (line_cnt_q == '0) && (pix_cnt_q == '0);
                push_word_q.eol  <= (pix_cnt_q == PIX_LAST);
                push_word_q.eof  <= (pix_cnt_q == PIX_LAST) && (line_cnt_q == LINE_LAST);
                push_word_q.data <= {hi_q, d_s[7:0]};
            end
        end
    end

    sync_fifo #(
        .WIDTH ($bits(pix_word_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .sys_clk (sys_clk),
        .rst_n   (rst_n),
        .wr_en   (push_vld_q),
        .wr_data (push_word_q),
        .rd_en   (pop),
        .rd_data (head),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign pix_valid_o = !fifo_empty;
    assign pop         = pix_valid_o && pix_ready_i;
    assign pix_data_o  = pix_valid_o ? head.data : 16'h0000;
    assign pix_sof_o   = pix_valid_o && head.sof;
    assign pix_eol_o   = pix_valid_o && head.eol;
    assign pix_eof_o   = pix_valid_o && head.eof;

    // Sticky error flags; a clear beats a same-cycle set.
    always_ff @(posedge sys_clk) begin
        if (!rst_n || err_clr_i) begin
            ovf_o <= 1'b0;
            err_o <= 1'b0;
        end else begin
            if (push_vld_q && fifo_full && !pop) ovf_o <= 1'b1;
            if (line_bad || drop_err)            err_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_dvp_rx_capture.sv
`timescale 1ns / 1ps
// Directed bench for dvp_rx_capture with a 4x2 image and a 4-entry FIFO.
module tb_dvp_rx_capture;

    logic        sys_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cap_en = 1'b0;
    logic        dvp_pclk_i = 1'b0;
    logic [7:0]  dvp_d_i = 8'h00;
    logic        dvp_href_i = 1'b0;
    logic        dvp_vsync_i = 1'b0;
    logic [15:0] pix_data_o;
    logic        pix_valid_o;
    logic        pix_ready_i = 1'b0;
    logic        pix_sof_o, pix_eol_o, pix_eof_o;
    logic        ovf_o, err_o;
    logic        err_clr_i = 1'b0;

    int          checks = 0;
    int          errors = 0;
    int          tx_cnt = 0;
    logic        pat6 = 1'b0;
    realtime     hp = 40.0;
    realtime     dly = 0.0;
    logic [18:0] rx_q[$];

    dvp_rx_capture #(
        .DVP_DATA_W (8),
        .IMG_W      (4),
        .IMG_H      (2),
        .FIFO_DEPTH (4)
    ) dut (
        .sys_clk     (sys_clk),
        .rst_n       (rst_n),
        .cap_en      (cap_en),
        .dvp_pclk_i  (dvp_pclk_i),
        .dvp_d_i     (dvp_d_i),
        .dvp_href_i  (dvp_href_i),
        .dvp_vsync_i (dvp_vsync_i),
        .pix_data_o  (pix_data_o),
        .pix_valid_o (pix_valid_o),
        .pix_ready_i (pix_ready_i),
        .pix_sof_o   (pix_sof_o),
        .pix_eol_o   (pix_eol_o),
        .pix_eof_o   (pix_eof_o),
        .ovf_o       (ovf_o),
        .err_o       (err_o),
        .err_clr_i   (err_clr_i)
    );

    always #5 sys_clk = ~sys_clk;

    // Record every accepted pixel as {sof, eol, eof, data}.
    always @(negedge sys_clk) begin
        if (pix_valid_o && pix_ready_i)
            rx_q.push_back({pix_sof_o, pix_eol_o, pix_eof_o, pix_data_o});
    end

    function automatic logic [7:0] tx_byte(int k);
        if (pat6) return 8'(k % 32);
        return 8'(32'h12 + 34 * k);
    endfunction

    // Expected pixel j of a clean 4x2 frame whose first byte index is base.
    function automatic logic [18:0] exp_pix(int base, int j);
        int l = j / 4;
        int p = j % 4;
        int k = base + l * 8 + 2 * p;
        return {(j == 0), (p == 3), (j == 7), tx_byte(k), tx_byte(k + 1)};
    endfunction

    task automatic align();
        @(posedge sys_clk);
        #2;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge sys_clk);
        #1;
    endtask

    task automatic pclk_tick(input logic [7:0] b, input logic h, input logic v);
        dvp_pclk_i = 1'b0;
        #(dly);
        dvp_d_i     = b;
        dvp_href_i  = h;
        dvp_vsync_i = v;
        #(hp - dly);
        dvp_pclk_i = 1'b1;
        #(hp);
    endtask

    task automatic vsync_pulse();
        for (int i = 0; i < 3; i++) pclk_tick(8'h00, 1'b0, 1'b1);
        for (int i = 0; i < 2; i++) pclk_tick(8'h00, 1'b0, 1'b0);
    endtask

    task automatic send_line(input int n_bytes);
        pclk_tick(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < n_bytes; i++) begin
            pclk_tick(tx_byte(tx_cnt), 1'b1, 1'b0);
            tx_cnt++;
        end
        pclk_tick(8'h00, 1'b0, 1'b0);
        pclk_tick(8'h00, 1'b0, 1'b0);
    endtask

    task automatic err_clr_pulse();
        @(posedge sys_clk);
        #1 err_clr_i = 1'b1;
        @(posedge sys_clk);
        #1 err_clr_i = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        wait_cycles(4);
        checks++; if (pix_valid_o !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", pix_valid_o); end
        checks++; if (pix_data_o !== 16'h0) begin errors++; $display("FAIL rst_data got %h want 0000", pix_data_o); end
        checks++; if (pix_sof_o !== 1'b0) begin errors++; $display("FAIL rst_sof got %b want 0", pix_sof_o); end
        checks++; if (pix_eol_o !== 1'b0) begin errors++; $display("FAIL rst_eol got %b want 0", pix_eol_o); end
        checks++; if (pix_eof_o !== 1'b0) begin errors++; $display("FAIL rst_eof got %b want 0", pix_eof_o); end
        checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL rst_ovf got %b want 0", ovf_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL rst_err got %b want 0", err_o); end
        rst_n = 1'b1;
    endtask

    task automatic test_frame();
        logic [18:0] got;
        pix_ready_i = 1'b1; cap_en = 1'b1; tx_cnt = 0; rx_q.delete();
        align();
        vsync_pulse();
        send_line(8);
        send_line(8);
        wait_cycles(10);
        checks++; if (rx_q.size() !== 8) begin errors++; $display("FAIL frame_count got %0d want 8", rx_q.size()); end
        for (int j = 0; j < 8; j++) begin
            got = (j < rx_q.size()) ? rx_q[j] : 'x;
            checks++;
            if (got !== exp_pix(0, j)) begin errors++; $display("FAIL frame_pix%0d got %h want %h", j, got, exp_pix(0, j)); end
        end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL frame_err got %b want 0", err_o); end
        checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL frame_ovf got %b want 0", ovf_o); end
    endtask

    task automatic test_overflow();
        logic [18:0] got;
        logic [18:0] first;
        pix_ready_i = 1'b0; tx_cnt = 0; rx_q.delete();
        align();
        vsync_pulse();
        send_line(8);
        send_line(2);
        wait_cycles(10);
        first = exp_pix(0, 0);
        checks++; if (pix_valid_o !== 1'b1) begin errors++; $display("FAIL ovf_valid got %b want 1", pix_valid_o); end
        checks++; if (pix_data_o !== first[15:0]) begin errors++; $display("FAIL ovf_head got %h want %h", pix_data_o, first[15:0]); end
        checks++; if (ovf_o !== 1'b1) begin errors++; $display("FAIL ovf_flag got %b want 1", ovf_o); end
        @(posedge sys_clk);
        #1 pix_ready_i = 1'b1;
        wait_cycles(10);
        checks++; if (rx_q.size() !== 4) begin errors++; $display("FAIL ovf_count got %0d want 4", rx_q.size()); end
        for (int j = 0; j < 4; j++) begin
            got = (j < rx_q.size()) ? rx_q[j] : 'x;
            checks++;
            if (got !== exp_pix(0, j)) begin errors++; $display("FAIL ovf_pix%0d got %h want %h", j, got, exp_pix(0, j)); end
        end
        err_clr_pulse();
        checks++; if (ovf_o !== 1'b0) begin errors++; $display("FAIL ovf_clr got %b want 0", ovf_o); end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL ovf_errclr got %b want 0", err_o); end
    endtask

    task automatic test_short_line();
        logic [18:0] got;
        logic [18:0] want;
        pix_ready_i = 1'b1; tx_cnt = 0; rx_q.delete();
        align();
        vsync_pulse();
        send_line(7);
        send_line(8);
        wait_cycles(10);
        checks++; if (rx_q.size() !== 7) begin errors++; $display("FAIL short_count got %0d want 7", rx_q.size()); end
        for (int j = 0; j < 7; j++) begin
            if (j < 3) want = {(j == 0), 1'b0, 1'b0, tx_byte(2 * j), tx_byte(2 * j + 1)};
            else       want = {1'b0, (j == 6), (j == 6), tx_byte(2 * j + 1), tx_byte(2 * j + 2)};
            got = (j < rx_q.size()) ? rx_q[j] : 'x;
            checks++;
            if (got !== want) begin errors++; $display("FAIL short_pix%0d got %h want %h", j, got, want); end
        end
        checks++; if (err_o !== 1'b1) begin errors++; $display("FAIL short_err got %b want 1", err_o); end
        err_clr_pulse();
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL short_errclr got %b want 0", err_o); end
    endtask

    task automatic test_cap_en();
        logic [18:0] got;
        int base;
        pix_ready_i = 1'b1; cap_en = 1'b0; tx_cnt = 0; rx_q.delete();
        align();
        vsync_pulse();
        send_line(8);
        cap_en = 1'b1;
        send_line(8);
        wait_cycles(10);
        checks++; if (rx_q.size() !== 0) begin errors++; $display("FAIL capen_off_count got %0d want 0", rx_q.size()); end
        align();
        vsync_pulse();
        base = tx_cnt;
        send_line(8);
        send_line(8);
        wait_cycles(10);
        checks++; if (rx_q.size() !== 8) begin errors++; $display("FAIL capen_on_count got %0d want 8", rx_q.size()); end
        for (int j = 0; j < 8; j += 7) begin
            got = (j < rx_q.size()) ? rx_q[j] : 'x;
            checks++;
            if (got !== exp_pix(base, j)) begin errors++; $display("FAIL capen_pix%0d got %h want %h", j, got, exp_pix(base, j)); end
        end
    endtask

    task automatic test_reset_mid();
        logic [18:0] got;
        int base;
        pix_ready_i = 1'b0; cap_en = 1'b1; tx_cnt = 0; rx_q.delete();
        align();
        vsync_pulse();
        pclk_tick(8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            pclk_tick(tx_byte(tx_cnt), 1'b1, 1'b0);
            tx_cnt++;
        end
        wait_cycles(8);
        checks++; if (pix_valid_o !== 1'b1) begin errors++; $display("FAIL rmid_pre_valid got %b want 1", pix_valid_o); end
        @(posedge sys_clk);
        #1 rst_n = 1'b0;
        repeat (2) @(posedge sys_clk);
        #1;
        checks++; if (pix_valid_o !== 1'b0) begin errors++; $display("FAIL rmid_valid got %b want 0", pix_valid_o); end
        checks++; if (pix_data_o !== 16'h0) begin errors++; $display("FAIL rmid_data got %h want 0000", pix_data_o); end
        checks++; if (pix_sof_o !== 1'b0) begin errors++; $display("FAIL rmid_sof got %b want 0", pix_sof_o); end
        @(posedge sys_clk);
        #1 rst_n = 1'b1;
        pix_ready_i = 1'b1;
        rx_q.delete();
        align();
        for (int i = 0; i < 5; i++) begin
            pclk_tick(tx_byte(tx_cnt), 1'b1, 1'b0);
            tx_cnt++;
        end
        pclk_tick(8'h00, 1'b0, 1'b0);
        send_line(8);
        wait_cycles(10);
        checks++; if (rx_q.size() !== 0) begin errors++; $display("FAIL rmid_none got %0d want 0", rx_q.size()); end
        align();
        vsync_pulse();
        base = tx_cnt;
        send_line(8);
        send_line(8);
        wait_cycles(10);
        checks++; if (rx_q.size() !== 8) begin errors++; $display("FAIL rmid_count got %0d want 8", rx_q.size()); end
        got = (rx_q.size() > 0) ? rx_q[0] : 'x;
        checks++; if (got !== exp_pix(base, 0)) begin errors++; $display("FAIL rmid_first got %h want %h", got, exp_pix(base, 0)); end
    endtask

    task automatic test_fast_pclk();
        logic [18:0] got;
        hp = 30.0; dly = 1.25; pat6 = 1'b1;
        pix_ready_i = 1'b1; cap_en = 1'b1; tx_cnt = 28; rx_q.delete();
        align();
        vsync_pulse();
        send_line(8);
        send_line(8);
        wait_cycles(10);
        checks++; if (rx_q.size() !== 8) begin errors++; $display("FAIL fast_count got %0d want 8", rx_q.size()); end
        for (int j = 0; j < 8; j++) begin
            got = (j < rx_q.size()) ? rx_q[j] : 'x;
            checks++;
            if (got !== exp_pix(28, j)) begin errors++; $display("FAIL fast_pix%0d got %h want %h", j, got, exp_pix(28, j)); end
        end
        checks++; if (err_o !== 1'b0) begin errors++; $display("FAIL fast_err got %b want 0", err_o); end
    endtask

    initial begin
        test_reset();
        test_frame();
        test_overflow();
        test_short_line();
        test_cap_en();
        test_reset_mid();
        test_fast_pclk();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
